// File: rtl/segasys1_pkg.sv
// Shared definitions for the Sega System 1 sound command path.
package segasys1_pkg;

  localparam int NMI_GAP_DEF    = 16;
  localparam int IRQ_PERIOD_DEF = 200000;

  typedef enum logic [1:0] {
    NMI_ST_IDLE   = 2'd0,
    NMI_ST_ASSERT = 2'd1,
    NMI_ST_GAP    = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/segasys1_cmdfifo.sv
// Small synchronous FIFO holding sound command bytes until the sound CPU reads them.
module segasys1_cmdfifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [7:0]            data_i,
  output logic [7:0]            head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr_q;
  logic [DEPTH_LOG2-1:0] rdPtr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  doPush;
  logic                  doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is accepted then.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      if (doPush && !doPop)      count_q <= count_q + 1'b1;
      else if (doPop && !doPush) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/segasys1_sndcmd_rx.sv
// Sound-side command receiver: request/read edge detection, command FIFO,
// edge-safe NMI generation, periodic sound IRQ and the read-data hold register.
module segasys1_sndcmd_rx
  import segasys1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_GAP    = NMI_GAP_DEF,
  parameter int IRQ_PERIOD = IRQ_PERIOD_DEF
) (
  input  logic       CLK48M,
  input  logic       RESET,
  input  logic       SNDRQ,
  input  logic [7:0] SNDNO,
  input  logic       SCPU_RD,
  input  logic       SCPU_IACK,
  output logic [7:0] SCPU_DO,
  output logic       SNDNMI,
  output logic       SNDIRQ,
  output logic       PENDING,
  output logic       OVF
);

  localparam int GAP_W = (NMI_GAP > 1) ? $clog2(NMI_GAP) : 1;
  localparam int IRQ_W = (IRQ_PERIOD > 1) ? $clog2(IRQ_PERIOD) : 1;

  logic                sndRq_q;
  logic                scpuRd_q;
  logic                iack_q;
  logic                push;
  logic                pop;
  logic                iackRise;

  logic [7:0]          fifoHead;
  logic [DEPTH_LOG2:0] fifoCount;
  logic                fifoFull;
  logic                fifoEmpty;

  logic                pending_q;
  logic                pending_d;
  logic                ovf_q;
  logic [7:0]          last_q;

  nmi_state_e          state_q;
  logic [GAP_W-1:0]    gapCnt_q;
  logic                nmi_q;

  logic [IRQ_W-1:0]    irqCnt_q;
  logic                irqWrap;
  logic                irq_q;

  assign push     = SNDRQ && !sndRq_q;
  assign pop      = !SCPU_RD && scpuRd_q;
  assign iackRise = SCPU_IACK && !iack_q;

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      sndRq_q  <= 1'b0;
      scpuRd_q <= 1'b0;
      iack_q   <= 1'b0;
    end else begin
      sndRq_q  <= SNDRQ;
      scpuRd_q <= SCPU_RD;
      iack_q   <= SCPU_IACK;
    end
  end

  segasys1_cmdfifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (CLK48M),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (SNDNO),
    .head_o  (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // PENDING rises one cycle after the first entry lands but falls together with the last pop.
  assign pending_d = !fifoEmpty &&
                     !((fifoCount == (DEPTH_LOG2+1)'(1)) && pop && !push);

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      last_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      if (push && fifoFull && !pop) ovf_q <= 1'b1;
      if (pop && !fifoEmpty)        last_q <= fifoHead;
    end
  end

  // Once NMI drops it stays low for NMI_GAP cycles so the Z80 always sees a fresh falling edge.
  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      state_q  <= NMI_ST_IDLE;
      gapCnt_q <= '0;
      nmi_q    <= 1'b0;
    end else begin
      unique case (state_q)
        NMI_ST_IDLE: begin
          if (pending_q) begin
            state_q <= NMI_ST_ASSERT;
            nmi_q   <= 1'b1;
          end
        end
        NMI_ST_ASSERT: begin
          if (pop) begin
            state_q  <= NMI_ST_GAP;
            gapCnt_q <= '0;
            nmi_q    <= 1'b0;
          end
        end
        NMI_ST_GAP: begin
          if (gapCnt_q == GAP_W'(NMI_GAP - 1)) begin
            if (!fifoEmpty) begin
              state_q <= NMI_ST_ASSERT;
              nmi_q   <= 1'b1;
            end else begin
              state_q <= NMI_ST_IDLE;
            end
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= NMI_ST_IDLE;
          nmi_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irqWrap = (irqCnt_q == IRQ_W'(IRQ_PERIOD - 1));

  always_ff @(posedge CLK48M or posedge RESET) begin
    if (RESET) begin
      irqCnt_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      irqCnt_q <= irqWrap ? '0 : irqCnt_q + 1'b1;
      if (irqWrap)       irq_q <= 1'b1;
      else if (iackRise) irq_q <= 1'b0;
    end
  end

  assign SCPU_DO = fifoEmpty ? last_q : fifoHead;
  assign SNDNMI  = nmi_q;
  assign SNDIRQ  = irq_q;
  assign PENDING = pending_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd_rx.sv
// Directed bench for segasys1_sndcmd_rx with a byte scoreboard on the read side.
module tb_segasys1_sndcmd_rx;

  localparam int NMI_GAP    = 16;
  localparam int IRQ_PERIOD = 100;
  localparam int DEPTH      = 4;

  logic       CLK48M = 1'b0;
  logic       RESET = 1'b1;
  logic       SNDRQ = 1'b0;
  logic [7:0] SNDNO = 8'h00;
  logic       SCPU_RD = 1'b0;
  logic       SCPU_IACK = 1'b0;
  logic [7:0] SCPU_DO;
  logic       SNDNMI;
  logic       SNDIRQ;
  logic       PENDING;
  logic       OVF;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] expQ [$];
  logic [7:0] lastExp = 8'h00;
  logic       expOvf = 1'b0;

  segasys1_sndcmd_rx #(
    .DEPTH_LOG2 (2),
    .NMI_GAP    (NMI_GAP),
    .IRQ_PERIOD (IRQ_PERIOD)
  ) dut (
    .CLK48M    (CLK48M),
    .RESET     (RESET),
    .SNDRQ     (SNDRQ),
    .SNDNO     (SNDNO),
    .SCPU_RD   (SCPU_RD),
    .SCPU_IACK (SCPU_IACK),
    .SCPU_DO   (SCPU_DO),
    .SNDNMI    (SNDNMI),
    .SNDIRQ    (SNDIRQ),
    .PENDING   (PENDING),
    .OVF       (OVF)
  );

  always #5 CLK48M = ~CLK48M;

  task automatic tick();
    @(posedge CLK48M);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_do"},   SCPU_DO, 8'h00);
    checkOutput({tag, "_nmi"},  {7'b0, SNDNMI}, 8'h00);
    checkOutput({tag, "_irq"},  {7'b0, SNDIRQ}, 8'h00);
    checkOutput({tag, "_pend"}, {7'b0, PENDING}, 8'h00);
    checkOutput({tag, "_ovf"},  {7'b0, OVF}, 8'h00);
  endtask

  // One write from the main CPU; the model predicts whether the FIFO accepts it.
  task automatic applyStimulus(input logic [7:0] b);
    SNDRQ = 1'b1;
    SNDNO = b;
    if (expQ.size() < DEPTH) expQ.push_back(b);
    else                     expOvf = 1'b1;
    tick();
    tick();
    SNDRQ = 1'b0;
    tick();
    tick();
  endtask

  task automatic waitForNmi(input string tag);
    int n;
    n = 0;
    while (SNDNMI !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checkOutput({tag, "_nmiwait"}, {7'b0, SNDNMI}, 8'h01);
  endtask

  task automatic readByte(input string tag, input bit waitNmi);
    logic [7:0] expv;
    if (waitNmi) waitForNmi(tag);
    SCPU_RD = 1'b1;
    tick();
    tick();
    if (expQ.size() != 0) begin
      expv    = expQ.pop_front();
      lastExp = expv;
    end else begin
      expv = lastExp;
    end
    checkOutput({tag, "_do"}, SCPU_DO, expv);
    SCPU_RD = 1'b0;
    tick();
    checkOutput({tag, "_nmidrop"}, {7'b0, SNDNMI}, 8'h00);
  endtask

  task automatic checkGap(input string tag);
    int lowCnt;
    lowCnt = 0;
    while (SNDNMI === 1'b0 && lowCnt < 100) begin
      lowCnt++;
      tick();
    end
    checks++;
    assert (lowCnt >= NMI_GAP && lowCnt < 100) else begin
      errors++;
      $error("[TB] FAIL %s nmi low cycles observed=%0d expected>=%0d", tag, lowCnt, NMI_GAP);
    end
  endtask

  initial begin
    bit nmiSeen;
    logic [7:0] expv;

    $display("[TB] reset values");
    repeat (3) tick();
    checkAllZero("reset");
    RESET = 1'b0;
    cyc = 0;

    $display("[TB] IRQ timer");
    while (cyc < IRQ_PERIOD - 1) tick();
    checkOutput("irq_pre", {7'b0, SNDIRQ}, 8'h00);
    tick();
    checkOutput("irq_rise", {7'b0, SNDIRQ}, 8'h01);
    repeat (10) tick();
    checkOutput("irq_hold", {7'b0, SNDIRQ}, 8'h01);
    SCPU_IACK = 1'b1;
    tick();
    checkOutput("irq_ack", {7'b0, SNDIRQ}, 8'h00);
    tick();
    tick();
    SCPU_IACK = 1'b0;
    while (cyc < 2 * IRQ_PERIOD - 1) tick();
    checkOutput("irq_pre2", {7'b0, SNDIRQ}, 8'h00);
    tick();
    checkOutput("irq_rearm", {7'b0, SNDIRQ}, 8'h01);

    $display("[TB] single push with long request level");
    SNDRQ = 1'b1;
    SNDNO = 8'h5A;
    expQ.push_back(8'h5A);
    tick();
    tick();
    checkOutput("t1_pend", {7'b0, PENDING}, 8'h01);
    checkOutput("t1_nmi_early", {7'b0, SNDNMI}, 8'h00);
    tick();
    checkOutput("t1_nmi_rise", {7'b0, SNDNMI}, 8'h01);
    checkOutput("t1_head", SCPU_DO, 8'h5A);
    repeat (5) tick();
    SNDRQ = 1'b0;
    tick();
    readByte("t1_rd", 1'b1);
    checkOutput("t1_onepush", {7'b0, PENDING}, 8'h00);
    repeat (20) tick();
    checkOutput("t1_hold", SCPU_DO, 8'h5A);

    $display("[TB] ordered reads with NMI gap");
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h03);
    readByte("t2_rd1", 1'b1);
    checkGap("t2_gap1");
    readByte("t2_rd2", 1'b1);
    checkGap("t2_gap2");
    readByte("t2_rd3", 1'b1);
    nmiSeen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      nmiSeen |= SNDNMI;
    end
    checkOutput("t2_nmi_quiet", {7'b0, nmiSeen}, 8'h00);
    checkOutput("t2_hold", SCPU_DO, 8'h03);

    $display("[TB] overflow");
    for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i));
    checkOutput("t3_ovf", {7'b0, OVF}, {7'b0, expOvf});
    for (int i = 0; i < 4; i++) readByte("t3_rd", 1'b1);
    checkOutput("t3_empty", {7'b0, PENDING}, 8'h00);
    checkOutput("t3_ovf_sticky", {7'b0, OVF}, {7'b0, expOvf});

    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    expQ.delete();
    lastExp = 8'h00;
    expOvf  = 1'b0;
    checkOutput("t3_ovf_clr", {7'b0, OVF}, 8'h00);

    $display("[TB] push and pop together while full");
    for (int i = 0; i < 4; i++) applyStimulus(8'hA0 + 8'(i));
    waitForNmi("t4");
    SCPU_RD = 1'b1;
    tick();
    tick();
    expv    = expQ.pop_front();
    lastExp = expv;
    checkOutput("t4_rd0", SCPU_DO, expv);
    SCPU_RD = 1'b0;
    SNDRQ   = 1'b1;
    SNDNO   = 8'hA4;
    expQ.push_back(8'hA4);
    tick();
    SNDRQ = 1'b0;
    checkOutput("t4_ovf", {7'b0, OVF}, 8'h00);
    checkOutput("t4_pend", {7'b0, PENDING}, 8'h01);
    for (int i = 0; i < 4; i++) readByte("t4_rd", 1'b1);
    checkOutput("t4_empty", {7'b0, PENDING}, 8'h00);
    checkOutput("t4_ovf_end", {7'b0, OVF}, 8'h00);

    $display("[TB] reset mid-operation");
    applyStimulus(8'hB0);
    applyStimulus(8'hB1);
    waitForNmi("t6");
    checkOutput("t6_pend", {7'b0, PENDING}, 8'h01);
    #3;
    RESET = 1'b1;
    #1;
    checkAllZero("t6_async");
    tick();
    tick();
    RESET = 1'b0;
    expQ.delete();
    lastExp = 8'h00;
    expOvf  = 1'b0;
    nmiSeen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      nmiSeen |= SNDNMI;
    end
    checkOutput("t6_no_nmi", {7'b0, nmiSeen}, 8'h00);
    checkOutput("t6_pend_clr", {7'b0, PENDING}, 8'h00);
    readByte("t6_rd", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segasys1_sndcmd_rx.md
# segasys1_sndcmd_rx

Sound-side receiver for the main CPU's sound request interface (`SNDRQ`/`SNDNO`).
- Captures each command byte into a small FIFO so that no command is lost while the slower sound Z80 is busy.
- Drives an edge-safe NMI toward the sound CPU and presents the head byte on its data bus.
- Also generates the periodic sound-CPU maskable IRQ.
- Sits between the main CPU block and the sound CPU/PSG subsystem.

## Interface
Parameters:
- `DEPTH_LOG2`, 2, FIFO depth is 2^DEPTH_LOG2 entries (default 4).
- `NMI_GAP`, 16, `CLK48M` cycles NMI is held low between consecutive commands.
- `IRQ_PERIOD`, 200000, `CLK48M` cycles between sound IRQs (4 per 60 Hz frame).

Ports:
- `CLK48M` in 1: system clock. One clock; all state is on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `SNDRQ` in 1: sound request level from the main CPU; high for one or more cycles per write.
- `SNDNO` in 8: command byte; valid while `SNDRQ` is high.
- `SCPU_RD` in 1: sound CPU read of the command latch address (mreq & rd & decode); level, may span many cycles.
- `SCPU_IACK` in 1: sound CPU interrupt acknowledge (m1 & iorq).
- `SCPU_DO` out 8: latch read data.
- `SNDNMI` out 1: NMI request to the sound CPU, active high.
- `SNDIRQ` out 1: IRQ request to the sound CPU, active high.
- `PENDING` out 1: FIFO non-empty.
- `OVF` out 1: sticky flag, set when a command was dropped because the FIFO was full.

## Operation
Push:
- A push occurs on the cycle where `SNDRQ` is high and its registered copy is low (rising edge).
- `SNDNO` is written at the write pointer and the pointer and count increment.
- A `SNDRQ` level that stays high never pushes twice.

Pop:
- A pop occurs on the falling edge of `SCPU_RD`, i.e. the cycle `SCPU_RD` is low and its registered copy is high.
- The read pointer advances and count decrements.
- A pop on an empty FIFO has no effect.

Read data:
- `SCPU_DO` = head entry while non-empty.
- When empty, `SCPU_DO` = last popped byte, held in a register.
- `SCPU_DO` is stable for the whole `SCPU_RD` level.

Full and simultaneous events:
- Push while full (count = 2^DEPTH_LOG2) with no pop in the same cycle: the byte is dropped, `OVF` is set, and pointers are unchanged.
- Push and pop in the same cycle: both occur and count is unchanged.
- This includes the full case: the push succeeds and `OVF` is not set.
- Pointers wrap modulo 2^DEPTH_LOG2. Count is DEPTH_LOG2+1 bits wide.

NMI FSM, with states IDLE, ASSERT, GAP:
- IDLE → ASSERT when count≠0.
- ASSERT → GAP on pop.
- GAP: counts `NMI_GAP` cycles, then → ASSERT if count≠0, else → IDLE.
- `SNDNMI` = (state==ASSERT).

IRQ timer:
- Free-running counter from 0 to `IRQ_PERIOD`-1.
- On wrap, `SNDIRQ` is set.
- `SNDIRQ` is cleared on the rising edge of `SCPU_IACK`.
- Wrap and ack in the same cycle: set wins.

## Timing
- Reset values:
  - pointers, count, counters = 0
  - FSM = IDLE
  - `SCPU_DO` = 8'h00
  - `SNDNMI` = 0, `SNDIRQ` = 0, `PENDING` = 0, `OVF` = 0
- Push latency:
  - `SNDNO` is captured at the first clock edge where `SNDRQ` is seen high.
  - `PENDING` rises 1 cycle later.
  - `SNDNMI` rises 2 cycles after that first edge.
- Pop latency:
  - count and `PENDING` update at the edge following the `SCPU_RD` fall cycle.
  - `SNDNMI` drops at that same edge.
  - The next entry appears on `SCPU_DO` at that same edge.
- Minimum NMI low time is `NMI_GAP` cycles. This guarantees a Z80 falling-edge retrigger with clock-enable rates down to 3 MHz.
- The first `SNDIRQ` occurs `IRQ_PERIOD` cycles after reset release.
- `RESET` mid-operation clears everything immediately:
  - FIFO contents are discarded.
  - No outputs glitch high.

## Structure
- Shared package `segasys1_pkg`: the `NMI_GAP`/`IRQ_PERIOD` defaults and the NMI FSM state encoding.
- One natural sub-module: `segasys1_cmdfifo`, a synchronous FIFO with push, pop, head, count and full/empty.
- The top level holds the edge detectors, the NMI FSM, the IRQ timer and the `SCPU_DO` hold register.

## Test plan
- Reset, then `SNDRQ` high for 8 cycles with `SNDNO`=8'h5A → exactly one push; `PENDING`=1; `SNDNMI` rises 2 cycles after `SNDRQ` first seen high; `SCPU_DO`=8'h5A.
- Push 8'h01, 8'h02, 8'h03, then pulse `SCPU_RD` 3 times, each ≥`NMI_GAP` apart → reads return 01, 02, 03 in order; `SNDNMI` low ≥16 cycles between reads; `SNDNMI` stays low and `SCPU_DO` holds 8'h03 after the last pop.
- Push 5 bytes 10–14 with no reads → `OVF`=1, count=4; reads return 10–13.
- Push coinciding with the `SCPU_RD` falling edge while full → count stays 4, `OVF` stays 0, new byte is read last.
- `IRQ_PERIOD` overridden to 100 → `SNDIRQ` rises at cycle 100, holds until the `SCPU_IACK` rising edge, and re-asserts at cycle 200.
- Assert `RESET` with 2 entries pending and `SNDNMI` high → all outputs 0 asynchronously; after release, reads return 8'h00 and no NMI occurs.
